// File: rtl/spi_slave_sync.sv
// spi_slave_sync: SPI slave oversampled in the clk_system domain with a one-word TX holding buffer.
module spi_slave_sync #(
  parameter int DATA_WIDTH  = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int MSB_FIRST   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_system,
  input  logic                  reset,
  input  logic                  sclk,
  input  logic                  mosi,
  input  logic                  slave_select_n,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  tx_underrun,
  output logic                  frame_error,
  output logic                  busy
);
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic POL = (CPOL != 0);
  localparam logic [CW-1:0] FULL = CW'(DATA_WIDTH);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state_q;
  logic [SYNC_STAGES-1:0] sclk_sync_q, ss_sync_q, mosi_sync_q;
  logic sclk_e_q, ss_e_q;
  logic [DATA_WIDTH-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, buf_q, rx_data_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic full_q, skip_q, miso_q, rx_valid_q, tx_underrun_q, frame_error_q;
  logic sclk_s, ss_s, mosi_s, lead, trail, sample, shift, active;
  logic ss_rise, ss_fall, leave, done, load, accept, shift_en, sample_en;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign ss_s   = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_system) begin
    if (reset) begin
      sclk_sync_q <= {SYNC_STAGES{POL}};
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_e_q    <= POL;
      ss_e_q      <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], slave_select_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sclk_e_q    <= sclk_s;
      ss_e_q      <= ss_s;
    end
  end

  always_comb begin
    lead      = (sclk_e_q == POL) && (sclk_s != POL);
    trail     = (sclk_e_q != POL) && (sclk_s == POL);
    sample    = (CPHA != 0) ? trail : lead;
    shift     = (CPHA != 0) ? lead : trail;
    active    = state_q == ACTIVE;
    ss_rise   = ss_s && !ss_e_q;
    ss_fall   = !ss_s && ss_e_q;
    leave     = active && ss_rise;
    done      = active && cnt_q == FULL;
    load      = (!active && ss_fall) || (done && !ss_rise);
    accept    = tx_valid && !full_q;
    shift_en  = active && !ss_rise && shift && !skip_q;
    sample_en = active && !ss_rise && sample;
    tx_sh_d   = load ? (full_q ? buf_q : '0) : leave ? '0 : !shift_en ? tx_sh_q :
                (MSB_FIRST != 0) ? tx_sh_q << 1 : tx_sh_q >> 1;
    rx_sh_d   = leave ? '0 : !sample_en ? rx_sh_q :
                (MSB_FIRST != 0) ? {rx_sh_q[DATA_WIDTH-2:0], mosi_s} : {mosi_s, rx_sh_q[DATA_WIDTH-1:1]};
    cnt_d     = (leave || done) ? '0 : sample_en ? cnt_q + 1'b1 : cnt_q;
  end

  // skip_q swallows the first shift edge after a load that already presents bit 0
  always_ff @(posedge clk_system) begin
    if (reset) begin
      state_q       <= IDLE;
      tx_sh_q       <= '0;
      rx_sh_q       <= '0;
      cnt_q         <= '0;
      buf_q         <= '0;
      full_q        <= 1'b0;
      skip_q        <= 1'b0;
      miso_q        <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= leave ? IDLE : (!active && ss_fall) ? ACTIVE : state_q;
      tx_sh_q       <= tx_sh_d;
      rx_sh_q       <= rx_sh_d;
      cnt_q         <= cnt_d;
      miso_q        <= (MSB_FIRST != 0) ? tx_sh_d[DATA_WIDTH-1] : tx_sh_d[0];
      if (accept) buf_q <= tx_data;
      full_q        <= accept || (full_q && !load);
      skip_q        <= load ? ((CPHA != 0) || active) : (active && shift) ? 1'b0 : skip_q;
      if (done) rx_data_q <= rx_sh_q;
      rx_valid_q    <= done;
      tx_underrun_q <= load && !full_q;
      frame_error_q <= leave && cnt_q != '0 && !done;
    end
  end

  assign miso        = miso_q;
  assign miso_oe     = !ss_s;
  assign tx_ready    = !full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = tx_underrun_q;
  assign frame_error = frame_error_q;
  assign busy        = active;
endmodule
